// File: rtl/lut_scan_pkg.sv
// Shared types and helpers for the LUT INIT scanner.
package lut_scan_pkg;

  // Width of the settle counter; SETTLE ranges over 0..15.
  localparam int unsigned SettleW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDone
  } scan_state_e;

  // Number of addresses swept for an n-input LUT.
  function automatic int unsigned depth(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/lut_init_scanner_if.sv
// Bus bundle between the scan trigger/result logic and the LUT INIT scanner.
interface lut_init_scanner_if
  import lut_scan_pkg::*;
#(
  parameter int unsigned N_IN  = 1,
  parameter int unsigned N_LUT = 4
);
  localparam int unsigned Depth = depth(N_IN);

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [N_IN-1:0]          lut_i;
  logic [N_LUT-1:0]         lut_o;
  logic [N_LUT*Depth-1:0]   init_out;
  logic [N_LUT*Depth-1:0]   exp_init;
  logic [N_LUT-1:0]         mismatch;

  // Scanner side.
  modport slave (
    input  start, lut_o, exp_init,
    output busy, done, lut_i, init_out, mismatch
  );

  // Trigger / LUT bank / result side.
  modport master (
    output start, lut_o, exp_init,
    input  busy, done, lut_i, init_out, mismatch
  );
endinterface

// File: rtl/lut_scan_timer.sv
// Settle down-counter: load on a new address, count down, flag zero when sampling is due.
module lut_scan_timer
  import lut_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);
  localparam logic [SettleW-1:0] LoadVal = SettleW'(SETTLE);

  logic [SettleW-1:0] cnt_d, cnt_q;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lut_init_scanner.sv
// LUT INIT scanner: sweeps all 2**N_IN addresses onto a shared LUT input bus, samples every
// LUT output after a settle window and rebuilds each LUT's INIT word.
// Optional feature: define SCAN_COMPARE_EN to compare the rebuilt INITs against exp_init at done.
module lut_init_scanner
  import lut_scan_pkg::*;
#(
  parameter int unsigned N_IN   = 1,
  parameter int unsigned N_LUT  = 4,
  parameter int unsigned SETTLE = 1
) (
  input logic                clk,
  input logic                rst_n,
  lut_init_scanner_if.slave  bus
);
  localparam int unsigned   Depth    = depth(N_IN);
  localparam logic [N_IN-1:0] LastAddr = N_IN'(Depth - 1);

  scan_state_e                      state_d, state_q;
  logic [N_IN-1:0]                  addr_d, addr_q;
  logic [N_LUT-1:0][Depth-1:0]      init_d, init_q;
  logic [N_LUT-1:0]                 mismatch_d;
  logic                             tmr_load, tmr_dec, tmr_zero;

  lut_scan_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  // Scan FSM, address stepping and INIT capture.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    init_d     = init_q;
    mismatch_d = '0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          init_d   = '0;
          addr_d   = '0;
          tmr_load = 1'b1;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          for (int k = 0; k < int'(N_LUT); k++) begin
            init_d[k][addr_q] = bus.lut_o[k];
          end
          if (addr_q == LastAddr) begin
            state_d = StDone;
          end else begin
            addr_d   = addr_q + 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Compare against the fully rebuilt word, including the bit captured on the final edge.
    for (int k = 0; k < int'(N_LUT); k++) begin
      mismatch_d[k] = (init_d[k] != bus.exp_init[k*Depth +: Depth]);
    end
  end

  // State, address and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      init_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      init_q  <= init_d;
    end
  end

`ifdef SCAN_COMPARE_EN
  logic [N_LUT-1:0] mismatch_q;

  // Compare result: cleared on an accepted start, registered on entry to DONE, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= '0;
    end else if ((state_q == StIdle) && bus.start) begin
      mismatch_q <= '0;
    end else if ((state_q == StDrive) && (state_d == StDone)) begin
      mismatch_q <= mismatch_d;
    end
  end

  assign bus.mismatch = mismatch_q;
`else
  // No compare logic: expected INIT and the compare vector are left unused.
  logic unused_compare;
  assign unused_compare = ^{mismatch_d, bus.exp_init};
  assign bus.mismatch   = '0;
`endif

  assign bus.busy     = (state_q == StDrive);
  assign bus.done     = (state_q == StDone);
  assign bus.lut_i    = (state_q == StDrive) ? addr_q : '0;
  assign bus.init_out = init_q;

endmodule

// File: tb/tb_lut_init_scanner.sv
// Self-checking bench for lut_init_scanner: four instances cover 1/2/4-input LUTs, zero and
// nonzero settle windows, and a LUT bank whose outputs lag the address by three cycles.
module tb_lut_init_scanner;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [15:0] cfg_a [4];
  logic [15:0] cfg_b [4];
  logic [15:0] cfg_c [4];
  logic [1:0]  pc1, pc2, pc3, pd1, pd2, pd3;

  lut_init_scanner_if #(.N_IN(1), .N_LUT(4)) if_a ();
  lut_init_scanner_if #(.N_IN(4), .N_LUT(4)) if_b ();
  lut_init_scanner_if #(.N_IN(2), .N_LUT(4)) if_c ();
  lut_init_scanner_if #(.N_IN(2), .N_LUT(4)) if_d ();

  lut_init_scanner #(.N_IN(1), .N_LUT(4), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  lut_init_scanner #(.N_IN(4), .N_LUT(4), .SETTLE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  lut_init_scanner #(.N_IN(2), .N_LUT(4), .SETTLE(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  lut_init_scanner #(.N_IN(2), .N_LUT(4), .SETTLE(1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LUT banks: A and B respond immediately, C and D see the address three cycles late.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if_a.lut_o[k] = cfg_a[k][{3'b000, if_a.lut_i}];
      if_b.lut_o[k] = cfg_b[k][if_b.lut_i];
      if_c.lut_o[k] = cfg_c[k][{2'b00, pc3}];
      if_d.lut_o[k] = cfg_c[k][{2'b00, pd3}];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc1 <= '0; pc2 <= '0; pc3 <= '0;
      pd1 <= '0; pd2 <= '0; pd3 <= '0;
    end else begin
      pc1 <= if_c.lut_i; pc2 <= pc1; pc3 <= pc2;
      pd1 <= if_d.lut_i; pd2 <= pd1; pd3 <= pd2;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] init_of(input int w);
    case (w)
      0:       return 64'(if_a.init_out);
      1:       return 64'(if_b.init_out);
      2:       return 64'(if_c.init_out);
      default: return 64'(if_d.init_out);
    endcase
  endfunction

  function automatic logic [63:0] done_of(input int w);
    case (w)
      0:       return 64'(if_a.done);
      1:       return 64'(if_b.done);
      2:       return 64'(if_c.done);
      default: return 64'(if_d.done);
    endcase
  endfunction

  function automatic logic [63:0] busy_of(input int w);
    case (w)
      0:       return 64'(if_a.busy);
      1:       return 64'(if_b.busy);
      2:       return 64'(if_c.busy);
      default: return 64'(if_d.busy);
    endcase
  endfunction

  function automatic logic [63:0] lut_i_of(input int w);
    case (w)
      0:       return 64'(if_a.lut_i);
      1:       return 64'(if_b.lut_i);
      2:       return 64'(if_c.lut_i);
      default: return 64'(if_d.lut_i);
    endcase
  endfunction

  function automatic logic [63:0] mismatch_of(input int w);
    case (w)
      0:       return 64'(if_a.mismatch);
      1:       return 64'(if_b.mismatch);
      2:       return 64'(if_c.mismatch);
      default: return 64'(if_d.mismatch);
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       if_a.start = v;
      1:       if_b.start = v;
      2:       if_c.start = v;
      default: if_d.start = v;
    endcase
  endtask

  task automatic set_exp(input int w, input logic [63:0] v);
    case (w)
      0:       if_a.exp_init = v[7:0];
      1:       if_b.exp_init = v;
      2:       if_c.exp_init = v[15:0];
      default: if_d.exp_init = v[15:0];
    endcase
  endtask

  // Reference INIT: each LUT's configured truth table, d bits per LUT, LUT 0 in the LSBs.
  function automatic logic [63:0] pack_init(input int d, input logic [15:0] v0,
                                            input logic [15:0] v1, input logic [15:0] v2,
                                            input logic [15:0] v3);
    logic [63:0] m;
    m = (64'd1 << d) - 64'd1;
    return (64'(v0) & m) | ((64'(v1) & m) << d) | ((64'(v2) & m) << (2 * d)) |
           ((64'(v3) & m) << (3 * d));
  endfunction

  function automatic logic [63:0] exp_mismatch(input int d, input logic [63:0] got_init,
                                               input logic [63:0] want);
    logic [63:0] r;
    logic [63:0] m;
    r = '0;
    m = (64'd1 << d) - 64'd1;
`ifdef SCAN_COMPARE_EN
    for (int k = 0; k < 4; k++) begin
      r[k] = (((got_init >> (k * d)) & m) != ((want >> (k * d)) & m));
    end
`endif
    return r;
  endfunction

  function automatic logic [63:0] perturb(input int d, input logic [63:0] v);
    if ($urandom_range(0, 1) == 1) begin
      return v ^ (64'd1 << $urandom_range(0, 4 * d - 1));
    end
    return v;
  endfunction

  // One scan from a negedge: start pulse, bounded wait for done, then result and pulse checks.
  task automatic run_scan(input int w, input int d, input logic [63:0] model,
                          input logic [63:0] exp_v, input int lat, input bit chk,
                          input string tag);
    int n;
    set_exp(w, exp_v);
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    n = 1;
    check_eq({tag, "_busy"}, busy_of(w), 64'd1);
    while (done_of(w) != 64'd1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_latency"}, 64'(n), 64'(lat));
    check_eq({tag, "_busy_at_done"}, busy_of(w), 64'd0);
    check_eq({tag, "_lut_i_at_done"}, lut_i_of(w), 64'd0);
    if (chk) begin
      check_eq({tag, "_init"}, init_of(w), model);
      check_eq({tag, "_mismatch"}, mismatch_of(w), exp_mismatch(d, model, exp_v));
    end
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done_of(w), 64'd0);
    if (chk) begin
      check_eq({tag, "_init_hold"}, init_of(w), model);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m;
    logic [63:0] e;
    int          n;
    int          dones;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cfg_a[k] = 16'(k);
      cfg_b[k] = '0;
      cfg_c[k] = '0;
    end
    for (int w = 0; w < 4; w++) begin
      set_start(w, 1'b0);
      set_exp(w, 64'd0);
    end

    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check_eq("reset_busy", busy_of(w), 64'd0);
      check_eq("reset_done", done_of(w), 64'd0);
      check_eq("reset_lut_i", lut_i_of(w), 64'd0);
      check_eq("reset_init", init_of(w), 64'd0);
      check_eq("reset_mismatch", mismatch_of(w), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // LUTs with INIT 0,1,2,3; compare word has LUT 2 bit 1 flipped.
    m = pack_init(2, cfg_a[0], cfg_a[1], cfg_a[2], cfg_a[3]);
    check_eq("t1_model", m, 64'hE4);
    e = m ^ (64'd1 << 5);
    run_scan(0, 2, m, e, 5, 1'b1, "t1");

    // 4-input LUT 0 with INIT A5C3, zero settle.
    cfg_b[0] = 16'hA5C3;
    for (int k = 1; k < 4; k++) cfg_b[k] = 16'($urandom);
    m = pack_init(16, cfg_b[0], cfg_b[1], cfg_b[2], cfg_b[3]);
    run_scan(1, 16, m, m, 17, 1'b1, "t2");
    check_eq("t2_slice0", init_of(1) & 64'hFFFF, 64'hA5C3);

    // Randomised truth tables and compare words.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        cfg_a[k] = 16'($urandom);
        cfg_b[k] = 16'($urandom);
      end
      m = pack_init(2, cfg_a[0], cfg_a[1], cfg_a[2], cfg_a[3]);
      run_scan(0, 2, m, perturb(2, m), 5, 1'b1, "rand_a");
      m = pack_init(16, cfg_b[0], cfg_b[1], cfg_b[2], cfg_b[3]);
      run_scan(1, 16, m, perturb(16, m), 17, 1'b1, "rand_b");
    end

    // Reset while address 1 is on the bus aborts the scan without a done pulse.
    for (int k = 0; k < 4; k++) cfg_a[k] = 16'(k);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    n = 1;
    while (lut_i_of(0) != 64'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_reached_addr1", lut_i_of(0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t3_busy", busy_of(0), 64'd0);
    check_eq("t3_done", done_of(0), 64'd0);
    check_eq("t3_lut_i", lut_i_of(0), 64'd0);
    check_eq("t3_init", init_of(0), 64'd0);
    check_eq("t3_mismatch", mismatch_of(0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_of(0) == 64'd1) dones++;
    end
    check_eq("t3_no_done", 64'(dones), 64'd0);
    m = pack_init(2, cfg_a[0], cfg_a[1], cfg_a[2], cfg_a[3]);
    run_scan(0, 2, m, m, 5, 1'b1, "t3_rescan");

    // Start held high: one done per scan, re-trigger only from IDLE.
    set_start(0, 1'b1);
    dones = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done_of(0) == 64'd1) dones++;
      if (i == 5)  check_eq("t4_done1", done_of(0), 64'd1);
      if (i == 6)  check_eq("t4_idle_gap", busy_of(0), 64'd0);
      if (i == 7)  check_eq("t4_rescan_busy", busy_of(0), 64'd1);
      if (i == 11) check_eq("t4_done2", done_of(0), 64'd1);
    end
    set_start(0, 1'b0);
    check_eq("t4_done_count", 64'(dones), 64'd2);
    @(negedge clk);
    check_eq("t4_released", busy_of(0), 64'd0);

    // Three-cycle LUT delay: SETTLE=3 reads it correctly, SETTLE=1 does not.
    cfg_c[0] = 16'h6; cfg_c[1] = 16'h9; cfg_c[2] = 16'h3; cfg_c[3] = 16'hA;
    m = pack_init(4, cfg_c[0], cfg_c[1], cfg_c[2], cfg_c[3]);
    run_scan(2, 4, m, m, 17, 1'b1, "t6_settle3");
    run_scan(3, 4, m, m, 9, 1'b0, "t6_settle1");
    check_eq("t6_settle1_wrong", 64'(init_of(3) != m), 64'd1);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) cfg_c[k] = 16'($urandom_range(0, 15));
      m = pack_init(4, cfg_c[0], cfg_c[1], cfg_c[2], cfg_c[3]);
      run_scan(2, 4, m, perturb(4, m), 17, 1'b1, "rand_c");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
